// File: rtl/hist_sram_slave_if.sv
// Avalon-MM command/response bundle between the system-console master and the histogram SRAM slave.
interface hist_sram_slave_if;
    logic [31:0] avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        avs_readdatavalid;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest, avs_readdatavalid
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest, avs_readdatavalid
    );
endinterface

// File: rtl/hist_sram_slave.sv
// Histogram SRAM slave: plain r/w window, atomic saturating increment window, control/status with bulk clear.
// Reads return one cycle after acceptance; increments occupy 3 cycles; clear sweeps one word per cycle.
module hist_sram_slave #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_clk,
    input  logic              clk_reset_reset_n,
    hist_sram_slave_if.slave  avs,
    output logic              clear_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, RMW_ADD, RMW_DONE, CLEAR} state_t;

    state_t              state;
    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   clr_ptr;
    logic [31:0]         rmw_word;
    logic                sat_sticky;
    logic [15:0]         inc_count;

    logic [1:0]          win;
    logic [ADDR_W-1:0]   idx;
    logic                wr;
    logic                rd;
    logic [32:0]         sum_full;
    logic [31:0]         sum_sat;
    logic                waitreq;
    logic                mem_we;
    logic [3:0]          mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic                unused_bits;

    assign win         = avs.avs_address[ADDR_W+3:ADDR_W+2];
    assign idx         = avs.avs_address[ADDR_W+1:2];
    assign unused_bits = ^{avs.avs_address[31:ADDR_W+4], avs.avs_address[1:0]};
    // A simultaneous read and write is a write; the read is dropped.
    assign wr          = avs.avs_write;
    assign rd          = avs.avs_read & ~avs.avs_write;
    assign sum_full    = {1'b0, rmw_word} + {1'b0, avs.avs_writedata};
    assign sum_sat     = sum_full[32] ? 32'hFFFF_FFFF : sum_full[31:0];

    always_comb begin
        waitreq   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = idx;
        mem_wdata = avs.avs_writedata;
        case (state)
            IDLE: begin
                if (wr && win == 2'b01) begin
                    waitreq = 1'b1;
                end else if (wr && win == 2'b00) begin
                    mem_we = 1'b1;
                    mem_be = avs.avs_byteenable;
                end
            end
            RMW_ADD: begin
                waitreq   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = 4'hF;
                mem_wdata = sum_sat;
            end
            CLEAR: begin
                waitreq   = 1'b1;
                mem_we    = 1'b1;
                mem_be    = 4'hF;
                mem_addr  = clr_ptr;
                mem_wdata = 32'h0;
            end
            default: ;
        endcase
    end

    assign avs.avs_waitrequest = waitreq;
    assign clear_busy          = (state == CLEAR);

    always_ff @(posedge clk_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge clk_reset_reset_n) begin
        if (!clk_reset_reset_n) begin
            state                 <= IDLE;
            clr_ptr               <= '0;
            rmw_word              <= 32'h0;
            sat_sticky            <= 1'b0;
            inc_count             <= 16'h0;
            avs.avs_readdata      <= 32'h0;
            avs.avs_readdatavalid <= 1'b0;
        end else begin
            avs.avs_readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd) begin
                        avs.avs_readdatavalid <= 1'b1;
                        case (win)
                            2'b00:   avs.avs_readdata <= mem[idx];
                            2'b10:   avs.avs_readdata <= {inc_count, 15'b0, sat_sticky};
                            default: avs.avs_readdata <= 32'h0;
                        endcase
                    end else if (wr) begin
                        if (win == 2'b01) begin
                            rmw_word <= mem[idx];
                            state    <= RMW_ADD;
                        end else if (win == 2'b10) begin
                            if (avs.avs_writedata[1]) begin
                                sat_sticky <= 1'b0;
                                inc_count  <= 16'h0;
                            end
                            if (avs.avs_writedata[0]) begin
                                clr_ptr <= '0;
                                state   <= CLEAR;
                            end
                        end
                    end
                end
                RMW_ADD: begin
                    if (sum_full[32]) sat_sticky <= 1'b1;
                    if (inc_count != 16'hFFFF) inc_count <= inc_count + 16'h1;
                    state <= RMW_DONE;
                end
                RMW_DONE: state <= IDLE;
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_sram_slave.sv
// Directed bench for hist_sram_slave (ADDR_W=4); reads feed an expected-data queue drained by a monitor.
module tb_hist_sram_slave;
    localparam int AW = 4;

    logic clk_clk = 1'b0;
    logic clk_reset_reset_n = 1'b0;
    logic clear_busy;

    hist_sram_slave_if bus_if ();

    hist_sram_slave #(.ADDR_W(AW)) dut (
        .clk_clk           (clk_clk),
        .clk_reset_reset_n (clk_reset_reset_n),
        .avs               (bus_if),
        .clear_busy        (clear_busy)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] a(input logic [1:0] w, input logic [3:0] i);
        return {24'b0, w, i, 2'b00};
    endfunction

    // Monitor: every read return is matched against the oldest expected value.
    always @(negedge clk_clk) begin
        if (clk_reset_reset_n && bus_if.avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rdv", 32'h1, 32'h0);
            end else begin
                chk("readdata", bus_if.avs_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle_bus();
        bus_if.avs_read       = 1'b0;
        bus_if.avs_write      = 1'b0;
        bus_if.avs_address    = 32'h0;
        bus_if.avs_writedata  = 32'h0;
        bus_if.avs_byteenable = 4'h0;
    endtask

    // Present a command and hold it until accepted; returns with inputs idled 1ns after the accepting edge.
    task automatic cmd(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input logic [31:0] exp, output int stalls);
        logic acc;
        stalls = 0;
        bus_if.avs_read       = rd;
        bus_if.avs_write      = wr;
        bus_if.avs_address    = addr;
        bus_if.avs_writedata  = data;
        bus_if.avs_byteenable = be;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk_clk);
            acc = !bus_if.avs_waitrequest;
            if (!acc) stalls++;
            if (stalls > 200) begin
                chk("accept_timeout", 32'h0, 32'h1);
                acc = 1'b1;
            end else if (acc && rd && !wr) begin
                exp_q.push_back(exp);
            end
            @(posedge clk_clk);
        end
        #1;
        idle_bus();
    endtask

    task automatic wr_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        int s;
        cmd(1'b0, 1'b1, addr, data, be, 32'h0, s);
    endtask

    task automatic rd_w(input logic [31:0] addr, input logic [31:0] exp);
        int s;
        cmd(1'b1, 1'b0, addr, 32'h0, 4'h0, exp, s);
    endtask

    initial begin
        int s;
        int busy_cycles;
        idle_bus();
        repeat (3) @(posedge clk_clk);
        #1;
        chk("rst_readdata", bus_if.avs_readdata, 32'h0);
        chk("rst_rdv", {31'b0, bus_if.avs_readdatavalid}, 32'h0);
        chk("rst_waitreq", {31'b0, bus_if.avs_waitrequest}, 32'h0);
        chk("rst_busy", {31'b0, clear_busy}, 32'h0);
        @(negedge clk_clk);
        clk_reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
        rd_w(a(2, 0), 32'h0);

        // Byte-lane merge, then read of the just-written word
        wr_w(a(0, 5), 32'hDEADBEEF, 4'hF);
        wr_w(a(0, 5), 32'h11223344, 4'h6);
        rd_w(a(0, 5), 32'hDE2233EF);
        chk("rd_latency", {31'b0, bus_if.avs_readdatavalid}, 32'h1);

        // Increment
        wr_w(a(0, 7), 32'd10, 4'hF);
        cmd(1'b0, 1'b1, a(1, 7), 32'd3, 4'h0, 32'h0, s);
        chk("inc_stalls", s, 32'd2);
        rd_w(a(0, 7), 32'd13);
        rd_w(a(2, 0), 32'h0001_0000);

        // Saturating increment and sticky/count clear
        wr_w(a(0, 2), 32'hFFFF_FFF0, 4'hF);
        wr_w(a(1, 2), 32'h20, 4'h0);
        rd_w(a(0, 2), 32'hFFFF_FFFF);
        rd_w(a(2, 0), 32'h0002_0001);
        wr_w(a(2, 0), 32'h2, 4'h0);
        rd_w(a(2, 0), 32'h0);

        // Reserved window: reads 0, writes ignored
        wr_w(a(3, 5), 32'h12345678, 4'hF);
        rd_w(a(3, 5), 32'h0);
        rd_w(a(0, 5), 32'hDE2233EF);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) wr_w(a(0, 4'(i)), 32'h100 + i, 4'hF);
        for (int i = 0; i < 4; i++) begin
            rd_w(a(0, 4'(i)), 32'h100 + i);
            chk("b2b_rdv", {31'b0, bus_if.avs_readdatavalid}, 32'h1);
        end

        // Clear with a read stalled behind it; increment first so 0x3 exercises both bits
        wr_w(a(1, 9), 32'h1, 4'h0);
        wr_w(a(2, 0), 32'h3, 4'h0);
        cmd(1'b1, 1'b0, a(0, 0), 32'h0, 4'h0, 32'h0, s);
        chk("clear_read_stalls", s, 32'd16);
        rd_w(a(2, 0), 32'h0);
        for (int i = 1; i < 16; i++) rd_w(a(0, 4'(i)), 32'h0);

        // Clear duration measured on clear_busy
        wr_w(a(2, 0), 32'h1, 4'h0);
        busy_cycles = 0;
        @(negedge clk_clk);
        while (clear_busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk_clk);
        end
        chk("clear_busy_cycles", busy_cycles, 32'd16);
        @(posedge clk_clk);
        #1;

        // Reset mid-clear
        wr_w(a(0, 3), 32'hAAAA_5555, 4'hF);
        wr_w(a(2, 0), 32'h1, 4'h0);
        repeat (3) @(posedge clk_clk);
        #1;
        chk("pre_rst_busy", {31'b0, clear_busy}, 32'h1);
        clk_reset_reset_n = 1'b0;
        #1;
        chk("rst_clear_busy", {31'b0, clear_busy}, 32'h0);
        chk("rst_clear_waitreq", {31'b0, bus_if.avs_waitrequest}, 32'h0);
        chk("rst_clear_readdata", bus_if.avs_readdata, 32'h0);
        @(negedge clk_clk);
        clk_reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
        cmd(1'b0, 1'b1, a(0, 6), 32'h6666, 4'hF, 32'h0, s);
        chk("post_rst_wr_stalls", s, 32'd0);

        // Reset mid-increment
        bus_if.avs_write     = 1'b1;
        bus_if.avs_address   = a(1, 6);
        bus_if.avs_writedata = 32'h1;
        @(posedge clk_clk);
        #1;
        chk("in_rmw_waitreq", {31'b0, bus_if.avs_waitrequest}, 32'h1);
        idle_bus();
        clk_reset_reset_n = 1'b0;
        #1;
        chk("rst_rmw_waitreq", {31'b0, bus_if.avs_waitrequest}, 32'h0);
        chk("rst_rmw_rdv", {31'b0, bus_if.avs_readdatavalid}, 32'h0);
        @(negedge clk_clk);
        clk_reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
        cmd(1'b0, 1'b1, a(0, 8), 32'h8888, 4'hF, 32'h0, s);
        chk("post_rmw_rst_stalls", s, 32'd0);
        rd_w(a(0, 8), 32'h8888);
        rd_w(a(2, 0), 32'h0);

        repeat (3) @(posedge clk_clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hist_sram_slave.md
# hist_sram_slave

Avalon-MM slave that terminates the system-console master port of the SRAM_SC subsystem and fronts an on-chip single-port histogram SRAM. Supports plain word reads/writes with byte enables, an atomic saturating increment window for histogram bin updates, and a control/status window with a hardware bulk-clear sweep. Sits directly downstream of the master and consumes its read/write/waitrequest/readdatavalid traffic.

## Interface
- ADDR_W, 10, word-address bits; SRAM depth 2^ADDR_W x 32
- clk_clk  in  1  sole clock, all logic rising-edge
- clk_reset_reset_n  in  1  reset, asynchronous assert, active-low
- avs_address  in  32  byte address; word index = [ADDR_W+1:2], window = [ADDR_W+3:ADDR_W+2], other bits ignored (aliased)
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  32  write data / increment operand
- avs_byteenable  in  4  byte lanes, plain writes only
- avs_readdata  out  32  read data, valid with avs_readdatavalid
- avs_waitrequest  out  1  command stall
- avs_readdatavalid  out  1  one-cycle read-return strobe
- clear_busy  out  1  high while bulk-clear sweep runs

## Operation
- Windows: 00 plain, 01 increment, 10 control/status, 11 reserved (reads return 0, writes accepted and ignored).
- Command accepted on any cycle with (read|write) && !avs_waitrequest. read and write together: treated as write, read dropped.
- FSM states IDLE, RMW_ADD, RMW_DONE, CLEAR.
- IDLE: plain read/write, status read, control write, reserved access accepted same cycle (waitrequest=0, combinational). Increment write: waitrequest=1, SRAM read of bin issued, go RMW_ADD.
- RMW_ADD: waitrequest=1; sum = SRAM word + writedata, saturating at 0xFFFFFFFF; write sum to bin; if saturated set sat_sticky; inc_count += 1 saturating at 0xFFFF; go RMW_DONE.
- RMW_DONE: waitrequest=0, increment accepted this cycle, go IDLE. Master must hold address/writedata stable throughout (Avalon rule).
- Plain write: only lanes with byteenable=1 updated. Byteenable ignored for reads, increments, control.
- Control write (window 10): writedata[1]=1 clears sat_sticky and inc_count; writedata[0]=1 enters CLEAR. Both may be set; both take effect.
- CLEAR: writes 0 to word 0,1,…,2^ADDR_W-1, one per cycle; clear_busy=1; waitrequest=1 for every command; last word written → IDLE.
- Status read returns {inc_count[15:0], 15'b0, sat_sticky}.
- SRAM array not reset; contents undefined after reset until written or cleared.

## Timing
- Reset values: avs_readdata=0, avs_readdatavalid=0, avs_waitrequest=0 (IDLE, no request), clear_busy=0, sat_sticky=0, inc_count=0, FSM=IDLE.
- Read latency fixed 1: read accepted cycle N → readdatavalid=1 with data at N+1. Back-to-back reads sustain one per cycle. avs_readdata holds last value otherwise.
- Increment occupancy 3 cycles (accepted at N+2 of first presentation); bin holds new value from N+2.
- Write at N, read of same word accepted N+1 returns written data (no stale read).
- Read accepted N-1, increment presented N: readdatavalid at N unaffected.
- CLEAR takes exactly 2^ADDR_W cycles after control-write acceptance; clear_busy falls the cycle FSM re-enters IDLE; first new command accepted that cycle.
- Reset mid-increment or mid-clear: FSM to IDLE immediately; partial bin write/sweep abandoned; no readdatavalid produced for reads pending at reset.

## Test plan
- Write 0xDEADBEEF to word 5, byteenable 0110 write 0x11223344 to word 5, read word 5 → readdatavalid next cycle, readdata 0xDE2233EF.
- Bin 7 preset 10; increment by 3 → waitrequest high 2 cycles, accepted 3rd; read bin 7 → 13; status → inc_count 1, sat_sticky 0.
- Bin 2 preset 0xFFFFFFF0; increment by 0x20 → bin 0xFFFFFFFF, sat_sticky 1; control write 0x2 → status 0x00000000.
- Control write 0x1 with ADDR_W=4 → clear_busy high exactly 16 cycles, read issued during sweep stalled until IDLE, then all 16 words read 0.
- Four back-to-back reads of words 0-3 → four consecutive readdatavalid pulses in order; reserved-window read → 0.
- Deassert clk_reset_reset_n mid-CLEAR and mid-increment → all outputs reset values same edge, FSM IDLE, next plain write accepted with no stall.
